// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiplier and
// restoring divider, N steps each, with Busy/Done handshake and MTHI/MTLO writes.
module mult_div_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [N-1:0] OperandA,
  input  logic [N-1:0] OperandB,
  input  logic         HiLoWrite,
  input  logic         HiLoSel,
  input  logic [N-1:0] WriteData,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [1:0]            op_p0;
  logic signed [N-1:0]   a_p0, b_p0;
  logic [N-1:0]          mag_a_p1, mag_b_p1;
  logic [2*N-1:0]        acc_p1;
  logic                  neg_q_p1, neg_r_p1;
  logic [CW-1:0]         cnt;
  logic                  done_r;

  logic                  is_signed, sign_a, sign_b;
  logic [N-1:0]          prep_ma, prep_mb;
  logic [N:0]            mul_sum, div_shift, div_diff;

  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v, input logic sgn);
    return (sgn && v < 0) ? (~v + N'(1)) : v;
  endfunction

  function automatic logic [N-1:0] fix_sign(input logic [N-1:0] v, input logic neg);
    return neg ? (~v + N'(1)) : v;
  endfunction

  function automatic logic [2*N-1:0] fix_sign_wide(input logic [2*N-1:0] v, input logic neg);
    return neg ? (~v + (2*N)'(1)) : v;
  endfunction

  always_comb begin
    is_signed = ~op_p0[0];
    sign_a    = is_signed & a_p0[N-1];
    sign_b    = is_signed & b_p0[N-1];
    prep_ma   = magnitude(a_p0, is_signed);
    prep_mb   = magnitude(b_p0, is_signed);
    mul_sum   = {1'b0, acc_p1[2*N-1:N]} + {1'b0, (acc_p1[0] ? mag_a_p1 : '0)};
    div_shift = acc_p1[2*N-1:N-1];
    div_diff  = div_shift - {1'b0, mag_b_p1};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt == CW'(N-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, magnitude prep, iterate, then sign-correct into Hi/Lo
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_p0    <= '0;
      a_p0     <= '0;
      b_p0     <= '0;
      mag_a_p1 <= '0;
      mag_b_p1 <= '0;
      acc_p1   <= '0;
      neg_q_p1 <= 1'b0;
      neg_r_p1 <= 1'b0;
      cnt      <= '0;
      done_r   <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (Start) begin
            op_p0 <= Op;
            a_p0  <= OperandA;
            b_p0  <= OperandB;
          end else if (HiLoWrite) begin
            if (HiLoSel) Hi <= WriteData;
            else         Lo <= WriteData;
          end
        end
        PREP: begin
          mag_a_p1 <= prep_ma;
          mag_b_p1 <= prep_mb;
          acc_p1   <= {{N{1'b0}}, (op_p0[1] ? prep_ma : prep_mb)};
          neg_q_p1 <= sign_a ^ sign_b;
          neg_r_p1 <= sign_a;
          cnt      <= '0;
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op_p0[1]) begin
            // Restoring step: keep the shifted remainder when the trial subtract underflows
            if (div_diff[N]) acc_p1 <= {div_shift[N-1:0], acc_p1[N-2:0], 1'b0};
            else             acc_p1 <= {div_diff[N-1:0], acc_p1[N-2:0], 1'b1};
          end else begin
            acc_p1 <= {mul_sum, acc_p1[N-1:1]};
          end
        end
        FIX: begin
          if (op_p0[1]) begin
            if (b_p0 == '0) begin
              Hi <= a_p0;
              Lo <= '1;
            end else begin
              Hi <= fix_sign(acc_p1[2*N-1:N], neg_r_p1);
              Lo <= fix_sign(acc_p1[N-1:0], neg_q_p1);
            end
          end else begin
            {Hi, Lo} <= fix_sign_wide(acc_p1, neg_q_p1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = done_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: cycle-exact Busy/Done windows, signed and
// unsigned results, divide-by-zero, overflow, direct writes and async reset.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        Clock, Reset, Start, HiLoWrite, HiLoSel, Busy, Done;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB, WriteData, Hi, Lo;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit #(.N(32), .CW(6)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiLoWrite(HiLoWrite), .HiLoSel(HiLoSel), .WriteData(WriteData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Called at a negedge; returns at the negedge of the Done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name, input bit inject);
    int busy_bad, done_bad;
    logic [31:0] hi_before;
    busy_bad  = 0;
    done_bad  = 0;
    hi_before = Hi;
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0; OperandA = ~a; OperandB = ~b;
    for (int i = 1; i <= 35; i++) begin
      if (i > 1) @(negedge Clock);
      if (Busy !== (i <= 34)) busy_bad++;
      if (Done !== (i == 35)) done_bad++;
      if (inject && i == 5) begin
        HiLoWrite = 1'b1; HiLoSel = 1'b1; WriteData = 32'hCAFEF00D;
        Start = 1'b1; Op = OP_DIV; OperandA = 32'h11111111; OperandB = 32'h3;
      end
      if (inject && i == 6) begin
        HiLoWrite = 1'b0; Start = 1'b0;
        n_cmp++;
        if (Hi !== hi_before) begin
          n_bad++;
          $display("FAIL %s busy_write_ignored: Hi=%h expected %h", name, Hi, hi_before);
        end
      end
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_bad++;
      $display("FAIL %s busy_window: %0d wrong cycles, expected 0", name, busy_bad);
    end
    n_cmp++;
    if (done_bad != 0) begin
      n_bad++;
      $display("FAIL %s done_pulse: %0d wrong cycles, expected 0", name, done_bad);
    end
    n_cmp++;
    if (Hi !== exp_hi) begin
      n_bad++;
      $display("FAIL %s hi: got %h expected %h", name, Hi, exp_hi);
    end
    n_cmp++;
    if (Lo !== exp_lo) begin
      n_bad++;
      $display("FAIL %s lo: got %h expected %h", name, Lo, exp_lo);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
    HiLoWrite = 1'b0; HiLoSel = 1'b0; WriteData = '0;
    repeat (2) @(negedge Clock);
    n_cmp++;
    if ({Busy, Done, Hi, Lo} !== 66'b0) begin
      n_bad++;
      $display("FAIL reset_state: Busy=%b Done=%b Hi=%h Lo=%h expected all 0", Busy, Done, Hi, Lo);
    end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_multu();
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0);
    @(negedge Clock);
    n_cmp++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL multu_after_done: Done=%b Busy=%b expected 0 0", Done, Busy);
    end
  endtask

  task automatic test_mult_back_to_back();
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg", 1'b0);
    run_op(OP_MULT, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, "mult_zero_b2b", 1'b0);
    @(negedge Clock);
  endtask

  task automatic test_div();
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg_dividend", 1'b0);
    @(negedge Clock);
    run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_neg_divisor", 1'b0);
    @(negedge Clock);
    run_op(OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100_7", 1'b0);
    @(negedge Clock);
  endtask

  task automatic test_div_zero();
    run_op(OP_DIVU, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu_by_zero", 1'b0);
    @(negedge Clock);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by_zero_neg", 1'b0);
    @(negedge Clock);
  endtask

  task automatic test_overflow();
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow", 1'b0);
    @(negedge Clock);
  endtask

  task automatic test_direct_write();
    bit seen;
    HiLoWrite = 1'b1; HiLoSel = 1'b1; WriteData = 32'hCAFEF00D;
    @(negedge Clock);
    HiLoWrite = 1'b0;
    n_cmp++;
    if (Hi !== 32'hCAFEF00D || Lo !== 32'h80000000 || Done !== 1'b0 || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL write_hi: Hi=%h Lo=%h Done=%b Busy=%b expected cafef00d 80000000 0 0",
               Hi, Lo, Done, Busy);
    end
    HiLoWrite = 1'b1; HiLoSel = 1'b0; WriteData = 32'h13579BDF;
    @(negedge Clock);
    HiLoWrite = 1'b0;
    n_cmp++;
    if (Lo !== 32'h13579BDF || Hi !== 32'hCAFEF00D || Done !== 1'b0) begin
      n_bad++;
      $display("FAIL write_lo: Hi=%h Lo=%h Done=%b expected cafef00d 13579bdf 0", Hi, Lo, Done);
    end
    Start = 1'b1; Op = OP_DIVU; OperandA = 32'h64; OperandB = 32'h7;
    HiLoWrite = 1'b1; HiLoSel = 1'b0; WriteData = 32'hDEADBEEF;
    @(negedge Clock);
    Start = 1'b0; HiLoWrite = 1'b0;
    n_cmp++;
    if (Lo !== 32'h13579BDF || Busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_beats_write: Lo=%h Busy=%b expected 13579bdf 1", Lo, Busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || Lo !== 32'h0000000E || Hi !== 32'h00000002) begin
      n_bad++;
      $display("FAIL start_beats_write_result: done=%b Hi=%h Lo=%h expected 1 00000002 0000000e",
               seen, Hi, Lo);
    end
    @(negedge Clock);
  endtask

  task automatic test_busy_ignore();
    run_op(OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "busy_ignore", 1'b1);
    @(negedge Clock);
    n_cmp++;
    if (Busy !== 1'b0 || Hi !== 32'h00000001 || Lo !== 32'h00000000) begin
      n_bad++;
      $display("FAIL busy_start_ignored: Busy=%b Hi=%h Lo=%h expected 0 00000001 00000000",
               Busy, Hi, Lo);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    Start = 1'b1; Op = OP_MULTU; OperandA = 32'hFFFFFFFF; OperandB = 32'hFFFFFFFF;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    for (int i = 2; i <= 11; i++) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0 || Done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: Busy=%b Done=%b Hi=%h Lo=%h expected 0 0 0 0", Busy, Done, Hi, Lo);
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL reset_abort: Done/Busy activity seen=%b expected 0", seen);
    end
    run_op(OP_DIVU, 32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, "divu_after_reset", 1'b0);
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_back_to_back();
    test_div();
    test_div_zero();
    test_overflow();
    test_direct_write();
    test_busy_ignore();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative MIPS multiply/divide unit directly downstream of the register file. Consumes ReadData1/ReadData2 as OperandA/OperandB and owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles using a shift-add multiplier and a restoring divider, with a Busy/Done handshake for the pipeline control.
- Also supports direct MTHI/MTLO writes. Hi/Lo feed the MFHI/MFLO path back toward register-file WriteData.

Parameters:
- N, 32, operand/result width. Only 32 is verified.
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with Start
- OperandA  input  N  rs value: multiplicand or dividend
- OperandB  input  N  rt value: multiplier or divisor
- HiLoWrite  input  1  direct write strobe (MTHI/MTLO)
- HiLoSel  input  1  0 writes Lo, 1 writes Hi
- WriteData  input  N  data for the direct write
- Hi  output  N  HI register
- Lo  output  N  LO register
- Busy  output  1  high whenever state is not IDLE
- Done  output  1  one-cycle pulse when Hi/Lo have just been updated by an operation

Behaviour:
- Reset is asynchronous and active-high. While asserted: state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter and datapath registers 0. Reset mid-operation aborts it: no Done pulse, Hi/Lo read 0.
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE: at an edge with Start=1, capture Op and both operands, then go to PREP.
  - Start outside IDLE is ignored; no queuing.
- PREP (1 cycle):
  - Signed ops (MULT, DIV): take the magnitude of each operand and record the result sign(s).
  - Unsigned ops: pass operands unchanged.
  - Clear the accumulator/remainder, load counter=0, go to CALC.
- CALC (exactly N cycles):
  - Multiply: one shift-add step per cycle on a 2N-bit product.
  - Divide: one restoring step per cycle (shift remainder, trial-subtract, set quotient bit).
  - Counter increments each cycle; after the step with counter=N-1, go to FIX.
- FIX (1 cycle):
  - Apply sign correction, write Hi/Lo, go to IDLE.
  - Done=1 in the cycle following this edge.
- Latency: with Start sampled at edge E0, Hi/Lo are updated at edge E0+N+2 (E34 for N=32). Done is high during cycle E34..E35. Busy is high from E0 through E34.
- Back-to-back: Start may be asserted in the Done cycle (state is IDLE) and is accepted.
- Results:
  - MULT/MULTU: {Hi,Lo} = full 2N-bit product, two's-complement for MULT. For MULT, negate the 2N-bit product iff the operand signs differ.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
  - DIV truncates toward zero: quotient negated iff signs differ; remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero (DIV or DIVU): Lo=all ones, Hi=OperandA (as captured). Normal latency, Done still pulses.
  - DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. This falls out of the magnitude path with no special case.
  - Operand zero for multiply: result 0, normal latency.
  - Operands change after Start: no effect; the captured copies are used.
- Direct write:
  - In IDLE with HiLoWrite=1 and Start=0: the selected register takes WriteData at the edge.
  - HiLoWrite while Busy is ignored. HiLoWrite together with Start in IDLE is ignored (Start wins).
  - Done is not asserted for direct writes.
- Hi/Lo hold their value at all other times.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, Start at E0: Busy high E0..E34, Done pulse after E34, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 0x00000007 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then MULT 0 x 0x12345678 started in the Done cycle -> Hi=0, Lo=0 at E+34.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 0x00000064 / 0x00000007 -> Lo=0x0000000E, Hi=0x00000002.
- Divide by zero: DIVU 0x00000064 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000064. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Direct writes: HiLoWrite, HiLoSel=1, WriteData=0xCAFEF00D in IDLE -> Hi=0xCAFEF00D next cycle, Done=0. The same write and a second Start issued while Busy are both ignored; Hi/Lo reflect only the first operation.
- Reset at cycle E10 of a MULTU -> Busy=0, Hi=Lo=0 immediately (asynchronous), no Done. A fresh DIVU 9/3 after release -> Lo=3, Hi=0 at +34.
